// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: Avalon-MM slave that sequences LED patterns onto an Avalon-MM PIO master port
// Ports: clk; reset_n (async, active-low);
//        slave  address[1:0], chipselect, write_n, writedata[25:0], readdata[25:0] (combinational);
//        master led_address[1:0] (const 0), led_chipselect, led_write_n, led_writedata[25:0].
// Registers: 0 PAT_A, 1 PAT_B, 2 PERIOD (ticks), 3 CTRL {BUSY, CUR_SEL, MODE, EN}.
// Option: define LED_ROTATE_EN to store CTRL.MODE; MODE=1 rotates PAT_A left by one bit per advance.
module led_pattern_ctrl #(
    parameter int PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [25:0] writedata,
    output logic [25:0] readdata,
    output logic [1:0]  led_address,
    output logic        led_chipselect,
    output logic        led_write_n,
    output logic [25:0] led_writedata
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {IDLE, LOAD, COUNT, WRITE, STOP} state_t;

    state_t        state;
    logic [25:0]   pat_a;
    logic [25:0]   pat_b;
    logic [23:0]   period;
    logic [23:0]   pcnt;
    logic [PW-1:0] presc;
    logic          en;
    logic          mode;
    logic          cur_sel;
    logic          wr;
    logic          period_wr;
    logic          tick;
    logic          terminal;
    logic          run;
    logic [25:0]   next_pat;

    assign wr          = chipselect && !write_n;
    assign period_wr   = wr && address == 2'd2;
    assign tick        = presc == PS_MAX;
    // PERIOD=0 behaves as PERIOD=1: every tick is terminal
    assign terminal    = tick && (period == 24'd0 || pcnt == period - 24'd1);
    // a PERIOD write restarts the count, so it also suppresses a coincident terminal
    assign run         = state == COUNT && en && !period_wr;
    assign led_address = 2'd0;

    always_comb
        readdata = address == 2'd0 ? pat_a :
                   address == 2'd1 ? pat_b :
                   address == 2'd2 ? {2'b0, period} :
                                     {22'b0, state != IDLE, cur_sel, mode, en};

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            pat_a  <= '0;
            pat_b  <= '0;
            period <= '0;
            en     <= 1'b0;
        end else if (wr) begin
            if (address == 2'd0) pat_a <= writedata;
            if (address == 2'd1) pat_b <= writedata;
            if (address == 2'd2) period <= writedata[23:0];
            if (address == 2'd3) en <= writedata[0];
        end

`ifdef LED_ROTATE_EN
    logic [25:0] cur_pat;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            mode <= 1'b0;
        else if (wr && address == 2'd3)
            mode <= writedata[1];

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            cur_pat <= '0;
        else if (state == LOAD)
            cur_pat <= pat_a;
        else if (run && terminal)
            cur_pat <= next_pat;

    assign next_pat = mode ? {cur_pat[24:0], cur_pat[25]} : cur_sel ? pat_a : pat_b;
`else
    assign mode     = 1'b0;
    assign next_pat = cur_sel ? pat_a : pat_b;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state          <= IDLE;
            presc          <= '0;
            pcnt           <= '0;
            cur_sel        <= 1'b0;
            led_chipselect <= 1'b0;
            led_write_n    <= 1'b1;
            led_writedata  <= '0;
        end else begin
            presc          <= run && !tick ? presc + PW'(1) : '0;
            pcnt           <= run && tick && !terminal ? pcnt + 24'd1 : run && !tick ? pcnt : '0;
            led_chipselect <= 1'b0;
            led_write_n    <= 1'b1;
            case (state)
                IDLE: if (en) state <= LOAD;
                LOAD: begin
                    state          <= WRITE;
                    cur_sel        <= 1'b0;
                    led_chipselect <= 1'b1;
                    led_write_n    <= 1'b0;
                    led_writedata  <= pat_a;
                end
                WRITE: begin
                    state <= en ? COUNT : STOP;
                    if (!en) begin
                        led_chipselect <= 1'b1;
                        led_write_n    <= 1'b0;
                        led_writedata  <= '0;
                    end
                end
                COUNT:
                    if (!en) begin
                        state          <= STOP;
                        led_chipselect <= 1'b1;
                        led_write_n    <= 1'b0;
                        led_writedata  <= '0;
                    end else if (run && terminal) begin
                        state          <= WRITE;
                        cur_sel        <= !mode && !cur_sel;
                        led_chipselect <= 1'b1;
                        led_write_n    <= 1'b0;
                        led_writedata  <= next_pat;
                    end
                STOP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed and randomized self-checking bench for led_pattern_ctrl
module tb_led_pattern_ctrl;
    localparam int P = 4;
`ifdef LED_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif
    localparam int M_IDLE = 0, M_LOAD = 1, M_WRITE = 2, M_COUNT = 3, M_STOP = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic [25:0] writedata = '0;
    logic [25:0] readdata;
    logic [25:0] led_writedata;
    logic [1:0]  led_address;
    logic        led_chipselect;
    logic        led_write_n;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model: m_left counts the cycles still to spend waiting before the next pattern write
    int          m_ph = M_IDLE;
    int          m_left = 0;
    logic        m_sel = 1'b0;
    logic        m_en = 1'b0;
    logic        m_mode = 1'b0;
    logic        m_cs = 1'b0;
    logic [25:0] m_pa = '0;
    logic [25:0] m_pb = '0;
    logic [25:0] m_pat = '0;
    logic [25:0] m_wd = '0;
    logic [23:0] m_per = '0;
    logic        m_wr;
    logic [23:0] m_per_next;

    led_pattern_ctrl #(.PRESCALE(P)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .led_address(led_address),
        .led_chipselect(led_chipselect),
        .led_write_n(led_write_n),
        .led_writedata(led_writedata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int span(input logic [23:0] per);
        return (per == 24'd0 ? 1 : int'(per)) * P;
    endfunction

    function automatic logic [25:0] exp_rd(input logic [1:0] a);
        return a == 2'd0 ? m_pa : a == 2'd1 ? m_pb : a == 2'd2 ? {2'b0, m_per} :
               {22'b0, m_ph != M_IDLE, m_sel, m_mode, m_en};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ph = M_IDLE; m_left = 0; m_sel = 0; m_en = 0; m_mode = 0; m_cs = 0;
            m_pa = '0; m_pb = '0; m_pat = '0; m_wd = '0; m_per = '0;
        end else begin
            m_wr = chipselect && !write_n;
            m_per_next = m_wr && address == 2'd2 ? writedata[23:0] : m_per;
            m_cs = 0;
            case (m_ph)
                M_IDLE: if (m_en) m_ph = M_LOAD;
                M_LOAD: begin
                    m_pat = m_pa; m_sel = 0; m_cs = 1; m_wd = m_pa; m_ph = M_WRITE;
                end
                M_WRITE:
                    if (m_en) begin
                        m_ph = M_COUNT; m_left = span(m_per_next);
                    end else begin
                        m_ph = M_STOP; m_cs = 1; m_wd = '0;
                    end
                M_COUNT:
                    if (!m_en) begin
                        m_ph = M_STOP; m_cs = 1; m_wd = '0;
                    end else if (m_wr && address == 2'd2)
                        m_left = span(m_per_next);
                    else if (m_left > 1)
                        m_left--;
                    else begin
                        if (m_mode) begin
                            m_pat = 26'((m_pat << 1) | (m_pat >> 25));
                            m_sel = 0;
                        end else begin
                            m_sel = !m_sel;
                            m_pat = m_sel ? m_pb : m_pa;
                        end
                        m_cs = 1; m_wd = m_pat; m_ph = M_WRITE;
                    end
                default: m_ph = M_IDLE;
            endcase
            if (m_wr)
                case (address)
                    2'd0: m_pa = writedata;
                    2'd1: m_pb = writedata;
                    2'd2: m_per = writedata[23:0];
                    default: begin m_en = writedata[0]; m_mode = ROT && writedata[1]; end
                endcase
        end
    end

    always @(negedge clk) begin
        chk("led_chipselect", 32'(led_chipselect), 32'(m_cs));
        chk("led_write_n", 32'(led_write_n), 32'(!m_cs));
        chk("led_writedata", 32'(led_writedata), 32'(m_wd));
        chk("led_address", 32'(led_address), 32'(0));
        chk("readdata", 32'(readdata), 32'(exp_rd(address)));
    end

    task automatic wr_reg(input logic [1:0] a, input logic [25:0] d, output int k);
        @(posedge clk); #2;
        k = cyc; address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #2;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic wait_write(output int t, output logic [25:0] d);
        t = -1;
        d = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (led_chipselect && !led_write_n) begin
                t = cyc;
                d = led_writedata;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_write: no LED write within 3000 cycles at cycle %0d", cyc);
    endtask

    initial begin
        int k, t1, t2, t3, n, r;
        logic [25:0] d1, d2, d3;
        repeat (3) @(posedge clk);
        #2 address = 2'd3;
        #1;
        chk("reset_cs", 32'(led_chipselect), 32'(0));
        chk("reset_wn", 32'(led_write_n), 32'(1));
        chk("reset_wd", 32'(led_writedata), 32'(0));
        chk("reset_ctrl", 32'(readdata), 32'(0));
        @(posedge clk); #2 reset_n = 1'b1;

        wr_reg(2'd0, 26'h1, k);
        wr_reg(2'd1, 26'h2, k);
        wr_reg(2'd2, 26'd2, k);
        wr_reg(2'd3, 26'd1, k);
        wait_write(t1, d1);
        wait_write(t2, d2);
        wait_write(t3, d3);
        chk("first_latency", 32'(t1 - k), 32'd3);
        chk("first_data", 32'(d1), 32'h1);
        chk("second_spacing", 32'(t2 - t1), 32'd9);
        chk("second_data", 32'(d2), 32'h2);
        chk("third_spacing", 32'(t3 - t2), 32'd9);
        chk("third_data", 32'(d3), 32'h1);

        repeat (3) @(posedge clk);
        wr_reg(2'd2, 26'd3, k);
        wait_write(t1, d1);
        chk("period_update_delay", 32'(t1 - k), 32'(3 * P + 1));
        chk("period_update_data", 32'(d1), 32'h2);

        repeat (4) @(posedge clk);
        wr_reg(2'd3, 26'd0, k);
        wait_write(t1, d1);
        chk("stop_delay", 32'(t1 - k), 32'd2);
        chk("stop_data", 32'(d1), 32'h0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (led_chipselect) n++;
        end
        chk("no_write_after_stop", 32'(n), 32'd0);
        @(posedge clk); #2 address = 2'd3;
        #1 chk("ctrl_after_stop", 32'(readdata), 32'h4);

        wr_reg(2'd2, 26'd0, k);
        wr_reg(2'd3, 26'd1, k);
        wait_write(t1, d1);
        wait_write(t2, d2);
        wait_write(t3, d3);
        chk("p0_latency", 32'(t1 - k), 32'd3);
        chk("p0_spacing1", 32'(t2 - t1), 32'd5);
        chk("p0_spacing2", 32'(t3 - t2), 32'd5);
        chk("p0_data", 32'({d1[3:0], d2[3:0], d3[3:0]}), 32'h121);

        wait_write(t1, d1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_cs", 32'(led_chipselect), 32'(0));
        chk("async_reset_wn", 32'(led_write_n), 32'(1));
        chk("async_reset_wd", 32'(led_writedata), 32'(0));
        chk("async_reset_ctrl", 32'(readdata), 32'(0));
        @(posedge clk); #2 reset_n = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (led_chipselect) n++;
        end
        chk("no_write_after_reset", 32'(n), 32'd0);

`ifdef LED_ROTATE_EN
        wr_reg(2'd0, 26'h2000001, k);
        wr_reg(2'd3, 26'd3, k);
        wait_write(t1, d1);
        wait_write(t2, d2);
        wait_write(t3, d3);
        chk("rot_w1", 32'(d1), 32'h2000001);
        chk("rot_w2", 32'(d2), 32'h0000003);
        chk("rot_w3", 32'(d3), 32'h0000006);
        wr_reg(2'd3, 26'd0, k);
        wait_write(t1, d1);
        chk("rot_stop", 32'(d1), 32'h0);
`endif

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            r = $urandom_range(0, 99);
            address = 2'($urandom_range(0, 3));
            chipselect = r < 15;
            write_n = !(r < 12 || r > 90);
            writedata = address >= 2'd2 ? 26'($urandom_range(0, 3)) : 26'($urandom);
            if (r == 50 && $urandom_range(0, 7) == 0) begin
                reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end
        chipselect = 1'b0;
        write_n = 1'b1;
        repeat (5) @(posedge clk);
        #2 $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
